// File: rtl/at_axi_kopru.sv
// at_axi_kopru: AXI4-Lite slave to at_* register-bus bridge for the SPI controller.
// Define AXI_TIMEOUT_EN to compile in the acknowledge timeout counter.
module at_axi_kopru #(
   parameter int ADRES_BIT = 32,
   parameter int TIMEOUT   = 255
) (
   input  logic                 clk_g,
   input  logic                 rst_g,
   input  logic [ADRES_BIT-1:0] axi_awaddr_g,
   input  logic                 axi_awvalid_g,
   output logic                 axi_awready_c,
   input  logic [31:0]          axi_wdata_g,
   input  logic [3:0]           axi_wstrb_g,
   input  logic                 axi_wvalid_g,
   output logic                 axi_wready_c,
   output logic [1:0]           axi_bresp_c,
   output logic                 axi_bvalid_c,
   input  logic                 axi_bready_g,
   input  logic [ADRES_BIT-1:0] axi_araddr_g,
   input  logic                 axi_arvalid_g,
   output logic                 axi_arready_c,
   output logic [31:0]          axi_rdata_c,
   output logic [1:0]           axi_rresp_c,
   output logic                 axi_rvalid_c,
   input  logic                 axi_rready_g,
   output logic [ADRES_BIT-1:0] at_adres_c,
   output logic [31:0]          at_yaz_veri_c,
   output logic                 at_yaz_gecerli_c,
   output logic                 at_gecerli_c,
   input  logic [31:0]          at_oku_veri_g,
   input  logic                 at_oku_gecerli_g,
   input  logic                 at_mesgul_g
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] ISTEK  = 3'd1;
   localparam logic [2:0] BEKLE  = 3'd2;
   localparam logic [2:0] BYANIT = 3'd3;
   localparam logic [2:0] RYANIT = 3'd4;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   localparam logic [15:0] SURE = 16'(TIMEOUT);

   logic [2:0] durum;
   logic       oncelik;
   logic       bos;
   logic       yaz_uygun;
   logic       oku_uygun;
   logic       yaz_sec;
   logic       oku_sec;
   logic       yasak;

`ifdef AXI_TIMEOUT_EN
   logic [15:0] sayac;
`else
   wire unused_sure = ^SURE;
`endif

   assign bos       = (durum == IDLE) && !rst_g;
   assign yaz_uygun = axi_awvalid_g && axi_wvalid_g;
   assign oku_uygun = axi_arvalid_g;

   // oncelik=1 lets a pending write beat a simultaneous read
   assign yaz_sec = bos && yaz_uygun && (oncelik || !oku_uygun);
   assign oku_sec = bos && oku_uygun && !yaz_sec;

   assign axi_awready_c = yaz_sec;
   assign axi_wready_c  = yaz_sec;
   assign axi_arready_c = oku_sec;

   assign yasak = yaz_sec
      ? ((axi_awaddr_g[1:0] != 2'b00) || (axi_wstrb_g != 4'hF))
      : (axi_araddr_g[1:0] != 2'b00);

   assign at_gecerli_c = (durum == ISTEK) && !at_mesgul_g;

   always_ff @(posedge clk_g or posedge rst_g) begin
      if (rst_g) begin
         durum            <= IDLE;
         oncelik          <= 1'b0;
         at_adres_c       <= '0;
         at_yaz_veri_c    <= '0;
         at_yaz_gecerli_c <= 1'b0;
         axi_bresp_c      <= OKAY;
         axi_bvalid_c     <= 1'b0;
         axi_rdata_c      <= '0;
         axi_rresp_c      <= OKAY;
         axi_rvalid_c     <= 1'b0;
`ifdef AXI_TIMEOUT_EN
         sayac            <= '0;
`endif
      end else begin
         case (durum)
            IDLE: begin
               if (yaz_sec || oku_sec) begin
                  oncelik          <= !oncelik;
                  at_yaz_gecerli_c <= yaz_sec;
                  at_adres_c       <= yaz_sec ? axi_awaddr_g : axi_araddr_g;
                  axi_rdata_c      <= '0;
                  if (yaz_sec)
                     at_yaz_veri_c <= axi_wdata_g;
                  if (!yasak) begin
                     durum <= ISTEK;
                  end else if (yaz_sec) begin
                     axi_bresp_c  <= SLVERR;
                     axi_bvalid_c <= 1'b1;
                     durum        <= BYANIT;
                  end else begin
                     axi_rresp_c  <= SLVERR;
                     axi_rvalid_c <= 1'b1;
                     durum        <= RYANIT;
                  end
               end
            end
            ISTEK: begin
               if (!at_mesgul_g) begin
                  durum <= BEKLE;
`ifdef AXI_TIMEOUT_EN
                  sayac <= SURE;
`endif
               end
            end
            BEKLE: begin
               if (at_oku_gecerli_g) begin
                  if (at_yaz_gecerli_c) begin
                     axi_bresp_c  <= OKAY;
                     axi_bvalid_c <= 1'b1;
                     durum        <= BYANIT;
                  end else begin
                     axi_rdata_c  <= at_oku_veri_g;
                     axi_rresp_c  <= OKAY;
                     axi_rvalid_c <= 1'b1;
                     durum        <= RYANIT;
                  end
               end
`ifdef AXI_TIMEOUT_EN
               // last counted cycle without acknowledge: give up
               else if (sayac <= 16'd1) begin
                  if (at_yaz_gecerli_c) begin
                     axi_bresp_c  <= SLVERR;
                     axi_bvalid_c <= 1'b1;
                     durum        <= BYANIT;
                  end else begin
                     axi_rresp_c  <= SLVERR;
                     axi_rvalid_c <= 1'b1;
                     durum        <= RYANIT;
                  end
               end else begin
                  sayac <= sayac - 16'd1;
               end
`endif
            end
            BYANIT: begin
               if (axi_bready_g) begin
                  axi_bvalid_c     <= 1'b0;
                  at_yaz_gecerli_c <= 1'b0;
                  durum            <= IDLE;
               end
            end
            RYANIT: begin
               if (axi_rready_g) begin
                  axi_rvalid_c <= 1'b0;
                  durum        <= IDLE;
               end
            end
            default: durum <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_at_axi_kopru.sv
// tb_at_axi_kopru: directed and random transactions against a
// cycle-count reference model of the bridge.
module tb_at_axi_kopru;

   localparam int TO = 5;
`ifdef AXI_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk_g = 1'b0;
   logic        rst_g = 1'b1;
   logic [31:0] axi_awaddr_g = '0;
   logic        axi_awvalid_g = 1'b0;
   logic        axi_awready_c;
   logic [31:0] axi_wdata_g = '0;
   logic [3:0]  axi_wstrb_g = '0;
   logic        axi_wvalid_g = 1'b0;
   logic        axi_wready_c;
   logic [1:0]  axi_bresp_c;
   logic        axi_bvalid_c;
   logic        axi_bready_g = 1'b0;
   logic [31:0] axi_araddr_g = '0;
   logic        axi_arvalid_g = 1'b0;
   logic        axi_arready_c;
   logic [31:0] axi_rdata_c;
   logic [1:0]  axi_rresp_c;
   logic        axi_rvalid_c;
   logic        axi_rready_g = 1'b0;
   logic [31:0] at_adres_c;
   logic [31:0] at_yaz_veri_c;
   logic        at_yaz_gecerli_c;
   logic        at_gecerli_c;
   logic [31:0] at_oku_veri_g = '0;
   logic        at_oku_gecerli_g = 1'b0;
   logic        at_mesgul_g = 1'b0;

   int n_asrt = 0;
   int n_fail = 0;

   at_axi_kopru #(.ADRES_BIT(32), .TIMEOUT(TO)) dut (
      .clk_g(clk_g), .rst_g(rst_g),
      .axi_awaddr_g(axi_awaddr_g), .axi_awvalid_g(axi_awvalid_g),
      .axi_awready_c(axi_awready_c),
      .axi_wdata_g(axi_wdata_g), .axi_wstrb_g(axi_wstrb_g),
      .axi_wvalid_g(axi_wvalid_g), .axi_wready_c(axi_wready_c),
      .axi_bresp_c(axi_bresp_c), .axi_bvalid_c(axi_bvalid_c),
      .axi_bready_g(axi_bready_g),
      .axi_araddr_g(axi_araddr_g), .axi_arvalid_g(axi_arvalid_g),
      .axi_arready_c(axi_arready_c),
      .axi_rdata_c(axi_rdata_c), .axi_rresp_c(axi_rresp_c),
      .axi_rvalid_c(axi_rvalid_c), .axi_rready_g(axi_rready_g),
      .at_adres_c(at_adres_c), .at_yaz_veri_c(at_yaz_veri_c),
      .at_yaz_gecerli_c(at_yaz_gecerli_c), .at_gecerli_c(at_gecerli_c),
      .at_oku_veri_g(at_oku_veri_g), .at_oku_gecerli_g(at_oku_gecerli_g),
      .at_mesgul_g(at_mesgul_g)
   );

   always #5 clk_g = ~clk_g;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic any_out();
      return |{axi_awready_c, axi_wready_c, axi_bresp_c, axi_bvalid_c,
               axi_arready_c, axi_rdata_c, axi_rresp_c, axi_rvalid_c,
               at_adres_c, at_yaz_veri_c, at_yaz_gecerli_c, at_gecerli_c};
   endfunction

   // Entered just after a rising edge; returns just after the edge that
   // follows the response handshake.
   task automatic run_txn(input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          input int busy, input int ackdly,
                          input logic [31:0] ackdat, input int rdly);
      int k, s, v, n_stb, wt, exp_s, exp_v;
      bit illegal, ack_ok, vld;
      logic [31:0] st_adr, st_wd, exp_rd, rd0;
      logic [1:0] exp_resp, rsp0;
      logic st_we;
      illegal = (addr[1:0] != 2'b00) || (wr && strb != 4'hF);
      exp_s   = busy + 1;
      ack_ok  = (ackdly > 0) && (!TO_EN || ackdly <= TO);
      if (illegal) begin
         exp_v = 1; exp_resp = 2'b10; exp_rd = '0;
      end else if (ack_ok) begin
         exp_v = exp_s + ackdly + 1; exp_resp = 2'b00; exp_rd = ackdat;
      end else begin
         exp_v = exp_s + TO + 1; exp_resp = 2'b10; exp_rd = '0;
      end
      st_adr = '0; st_wd = '0; st_we = 1'b0;
      if (wr) begin
         axi_awaddr_g = addr; axi_wdata_g = data; axi_wstrb_g = strb;
         axi_awvalid_g = 1'b1; axi_wvalid_g = 1'b1;
         axi_bready_g = (rdly == 0);
      end else begin
         axi_araddr_g = addr; axi_arvalid_g = 1'b1;
         axi_rready_g = (rdly == 0);
      end
      wt = 0;
      @(negedge clk_g);
      while (!((wr && axi_awready_c && axi_wready_c) ||
               (!wr && axi_arready_c)) && wt < 10) begin
         @(posedge clk_g); #1;
         @(negedge clk_g);
         wt++;
      end
      chk("accept_wait", wt, 0);
      chk("other_ready", wr ? axi_arready_c : (axi_awready_c | axi_wready_c), 0);
      @(posedge clk_g); #1;
      if (wr) begin
         axi_awvalid_g = 1'b0; axi_wvalid_g = 1'b0;
      end else begin
         axi_arvalid_g = 1'b0;
      end
      k = 1; s = 0; v = 0; n_stb = 0;
      while (v == 0 && k < 400) begin
         at_mesgul_g = (k <= busy);
         at_oku_gecerli_g = (s > 0 && ackdly > 0 && k == s + ackdly) ||
                            (k <= busy && $urandom_range(0, 1) == 1);
         at_oku_veri_g = (s > 0 && k == s + ackdly) ? ackdat : $urandom;
         @(negedge clk_g);
         chk("ready_busy", {29'b0, axi_awready_c, axi_wready_c, axi_arready_c}, 0);
         if (at_gecerli_c) begin
            n_stb++;
            if (s == 0) begin
               s = k; st_adr = at_adres_c; st_wd = at_yaz_veri_c;
               st_we = at_yaz_gecerli_c;
            end
         end
         vld = wr ? axi_bvalid_c : axi_rvalid_c;
         if (vld) v = k;
         else begin
            @(posedge clk_g); #1;
            k++;
         end
      end
      chk("valid_seen", v != 0, 1);
      chk("valid_cycle", v, exp_v);
      chk("strobe_count", n_stb, illegal ? 0 : 1);
      if (!illegal) begin
         chk("strobe_cycle", s, exp_s);
         chk("strobe_adres", st_adr, addr);
         chk("strobe_we", st_we, wr);
         if (wr) chk("strobe_wdata", st_wd, data);
      end
      rsp0 = wr ? axi_bresp_c : axi_rresp_c;
      rd0  = axi_rdata_c;
      chk("resp", rsp0, exp_resp);
      if (!wr) chk("rdata", rd0, exp_rd);
      for (int i = 0; i < rdly; i++) begin
         @(posedge clk_g); #1;
         at_oku_gecerli_g = 1'b0; at_mesgul_g = 1'b0;
         if (i == rdly - 1) begin
            if (wr) axi_bready_g = 1'b1; else axi_rready_g = 1'b1;
         end
         @(negedge clk_g);
         chk("valid_hold", wr ? axi_bvalid_c : axi_rvalid_c, 1);
         chk("resp_hold", wr ? axi_bresp_c : axi_rresp_c, rsp0);
         if (!wr) chk("rdata_hold", axi_rdata_c, rd0);
      end
      @(posedge clk_g); #1;
      at_oku_gecerli_g = 1'b0; at_mesgul_g = 1'b0;
      axi_bready_g = 1'b0; axi_rready_g = 1'b0;
      chk("valid_drop", wr ? axi_bvalid_c : axi_rvalid_c, 0);
   endtask

   initial begin
      bit wr;
      logic [31:0] ad, dt, ak;
      logic [3:0] sb;
      int bz, ad_dly, rd_dly;

      repeat (3) @(posedge clk_g);
      @(negedge clk_g);
      chk("reset_outputs", any_out(), 0);
      @(posedge clk_g); #1;
      rst_g = 1'b0;

      // tie straight after reset: read wins, write waits
      axi_awaddr_g = 32'h14; axi_wdata_g = 32'hDEAD0001;
      axi_wstrb_g = 4'hF; axi_awvalid_g = 1'b1; axi_wvalid_g = 1'b1;
      run_txn(1'b0, 32'h0C, 32'h0, 4'h0, 3, 2, 32'h1234_5678, 0);
      run_txn(1'b1, 32'h14, 32'hDEAD0001, 4'hF, 0, 1, 32'h0, 1);

      run_txn(1'b1, 32'h10, 32'h0000_2105, 4'hF, 0, 1, 32'h0, 0);

      // round-robin now favours the write
      axi_araddr_g = 32'h18; axi_arvalid_g = 1'b1;
      run_txn(1'b1, 32'h1C, 32'h0BAD_F00D, 4'hF, 0, 2, 32'h0, 0);
      run_txn(1'b0, 32'h18, 32'h0, 4'h0, 0, 1, 32'h7777_0001, 0);

      run_txn(1'b0, 32'h08, 32'h0, 4'h0, 0, 4, 32'hA5A5_0F0F, 3);
      run_txn(1'b0, 32'h08, 32'h0, 4'h0, 0, TO_EN ? -1 : 20,
              32'h5A5A_F0F0, 0);
      run_txn(1'b1, 32'h06, 32'h1111_2222, 4'hF, 0, 1, 32'h0, 0);
      run_txn(1'b1, 32'h10, 32'h3333_4444, 4'h3, 0, 1, 32'h0, 1);
      run_txn(1'b0, 32'h21, 32'h0, 4'h0, 0, 1, 32'h9, 0);

      // reset while waiting for acknowledge
      axi_araddr_g = 32'h20; axi_arvalid_g = 1'b1; axi_rready_g = 1'b1;
      @(negedge clk_g);
      chk("rst_accept", axi_arready_c, 1);
      @(posedge clk_g); #1;
      axi_arvalid_g = 1'b0;
      @(negedge clk_g);
      chk("rst_strobe", at_gecerli_c, 1);
      @(posedge clk_g); #1;
      rst_g = 1'b1;
      @(posedge clk_g); #1;
      chk("midreset_outputs", any_out(), 0);
      @(negedge clk_g);
      rst_g = 1'b0;
      @(posedge clk_g); #1;
      at_oku_gecerli_g = 1'b1; at_oku_veri_g = 32'hFEED_BEEF;
      @(posedge clk_g); #1;
      at_oku_gecerli_g = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_g);
         chk("late_ack_ignored", {30'b0, axi_rvalid_c, at_gecerli_c}, 0);
      end
      axi_rready_g = 1'b0;
      @(posedge clk_g); #1;

      // round-robin bit cleared by reset: read wins again
      axi_awaddr_g = 32'h24; axi_wdata_g = 32'h0000_00AA;
      axi_wstrb_g = 4'hF; axi_awvalid_g = 1'b1; axi_wvalid_g = 1'b1;
      run_txn(1'b0, 32'h28, 32'h0, 4'h0, 1, 1, 32'hC0DE_0001, 0);
      run_txn(1'b1, 32'h24, 32'h0000_00AA, 4'hF, 0, 3, 32'h0, 0);

      for (int n = 0; n < 40; n++) begin
         wr = 1'($urandom_range(0, 1));
         ad = {22'b0, 8'($urandom), 2'b00};
         if ($urandom_range(0, 5) == 0) ad[1:0] = 2'($urandom_range(1, 3));
         dt = $urandom;
         sb = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
         bz = $urandom_range(0, 3);
         if (TO_EN && $urandom_range(0, 4) == 0) ad_dly = -1;
         else ad_dly = $urandom_range(1, 8);
         ak = $urandom;
         rd_dly = $urandom_range(0, 2);
         run_txn(wr, ad, dt, sb, bz, ad_dly, ak, rd_dly);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asrt, n_fail);
      $finish;
   end

endmodule
